bmem_arbiter: RTL and testbench

Shares the single 64-bit burst memory port (bmem) between the instruction cache and data cache DFP ports. Accepts one 256-bit line request at a time, serializes write-backs into four 64-bit beats, and deserializes four read beats into a 256-bit line. It sits between both caches and the top-level bmem interface and is the only block that drives bmem.

---
 rtl/bmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_bmem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_arbiter.sv
// Shares the 64-bit burst memory port between I-cache and D-cache, one 256-bit line at a time.
// Optional BMEM_ARB_RR_EN: round-robin arbitration instead of fixed D-cache priority.
module bmem_arbiter #(
   parameter int BEATS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         i_dfp_addr,
   input  logic                i_dfp_read,
   output logic [64*BEATS-1:0] i_dfp_rdata,
   output logic                i_dfp_resp,
   input  logic [31:0]         d_dfp_addr,
   input  logic                d_dfp_read,
   input  logic                d_dfp_write,
   input  logic [64*BEATS-1:0] d_dfp_wdata,
   output logic [64*BEATS-1:0] d_dfp_rdata,
   output logic                d_dfp_resp,
   output logic [31:0]         bmem_addr,
   output logic                bmem_read,
   output logic                bmem_write,
   output logic [63:0]         bmem_wdata,
   input  logic                bmem_ready,
   input  logic [31:0]         bmem_raddr,
   input  logic [63:0]         bmem_rdata,
   input  logic                bmem_rvalid
);
   localparam int LINE_W = 64 * BEATS;

   typedef enum logic [2:0] {IDLE, WR_BURST, RD_REQ, RD_WAIT, RESP} state_t;

   state_t              state;
   logic [1:0]          cnt;
   logic [1:0]          cnt_nxt;
   logic                owner_d;
   logic [LINE_W-1:0]   wline;
   logic [LINE_W-1:0]   rline;
   logic                d_req;
   logic                i_req;
   logic                grant_d;
   logic                grant_i;
   logic                unused_addr_lsb;
`ifdef BMEM_ARB_RR_EN
   logic                prio_d;
`endif

   assign unused_addr_lsb = ^{i_dfp_addr[4:0], d_dfp_addr[4:0]};

   always_comb begin
      d_req   = d_dfp_read | d_dfp_write;
      i_req   = i_dfp_read;
`ifdef BMEM_ARB_RR_EN
      grant_d = d_req && (!i_req || prio_d);
`else
      grant_d = d_req;
`endif
      grant_i = i_req && !grant_d;
      cnt_nxt = cnt + 2'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         owner_d     <= 1'b0;
         wline       <= '0;
         rline       <= '0;
         i_dfp_rdata <= '0;
         i_dfp_resp  <= 1'b0;
         d_dfp_rdata <= '0;
         d_dfp_resp  <= 1'b0;
         bmem_addr   <= '0;
         bmem_read   <= 1'b0;
         bmem_write  <= 1'b0;
         bmem_wdata  <= '0;
`ifdef BMEM_ARB_RR_EN
         prio_d      <= 1'b1;
`endif
      end else begin
         i_dfp_resp <= 1'b0;
         d_dfp_resp <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d || grant_i) begin
                  owner_d   <= grant_d;
                  cnt       <= '0;
                  bmem_addr <= grant_d ? {d_dfp_addr[31:5], 5'b0} : {i_dfp_addr[31:5], 5'b0};
`ifdef BMEM_ARB_RR_EN
                  prio_d    <= !grant_d;
`endif
                  if (grant_d && d_dfp_write) begin
                     wline      <= d_dfp_wdata;
                     bmem_wdata <= d_dfp_wdata[63:0];
                     bmem_write <= 1'b1;
                     state      <= WR_BURST;
                  end else begin
                     bmem_read  <= 1'b1;
                     state      <= RD_REQ;
                  end
               end
            end
            WR_BURST: begin
               // Present the next beat only once the current one is accepted.
               if (bmem_ready) begin
                  cnt <= cnt_nxt;
                  if (cnt == 2'd3) begin
                     bmem_write <= 1'b0;
                     d_dfp_resp <= 1'b1;
                     state      <= RESP;
                  end else begin
                     bmem_wdata <= wline[{cnt_nxt, 6'b0} +: 64];
                  end
               end
            end
            RD_REQ: begin
               if (bmem_ready) begin
                  bmem_read <= 1'b0;
                  state     <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               // Beats tagged for another line are dropped.
               if (bmem_rvalid && (bmem_raddr == bmem_addr)) begin
                  rline[{cnt, 6'b0} +: 64] <= bmem_rdata;
                  cnt <= cnt_nxt;
                  if (cnt == 2'd3) begin
                     if (owner_d) begin
                        d_dfp_rdata <= {bmem_rdata, rline[LINE_W-65:0]};
                        d_dfp_resp  <= 1'b1;
                     end else begin
                        i_dfp_rdata <= {bmem_rdata, rline[LINE_W-65:0]};
                        i_dfp_resp  <= 1'b1;
                     end
                     state <= RESP;
                  end
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter: reads, stalled write-back, arbitration, tag filtering, mid-burst reset.
module tb_bmem_arbiter;
   logic         clk;
   logic         rst;
   logic [31:0]  i_dfp_addr;
   logic         i_dfp_read;
   logic [255:0] i_dfp_rdata;
   logic         i_dfp_resp;
   logic [31:0]  d_dfp_addr;
   logic         d_dfp_read;
   logic         d_dfp_write;
   logic [255:0] d_dfp_wdata;
   logic [255:0] d_dfp_rdata;
   logic         d_dfp_resp;
   logic [31:0]  bmem_addr;
   logic         bmem_read;
   logic         bmem_write;
   logic [63:0]  bmem_wdata;
   logic         bmem_ready;
   logic [31:0]  bmem_raddr;
   logic [63:0]  bmem_rdata;
   logic         bmem_rvalid;

   int vectors;
   int miscompares;

`ifdef BMEM_ARB_RR_EN
   localparam bit FIRST_IS_D = 1'b0;
`else
   localparam bit FIRST_IS_D = 1'b1;
`endif

   bmem_arbiter #(.BEATS(4)) dut (
      .clk(clk), .rst(rst),
      .i_dfp_addr(i_dfp_addr), .i_dfp_read(i_dfp_read),
      .i_dfp_rdata(i_dfp_rdata), .i_dfp_resp(i_dfp_resp),
      .d_dfp_addr(d_dfp_addr), .d_dfp_read(d_dfp_read), .d_dfp_write(d_dfp_write),
      .d_dfp_wdata(d_dfp_wdata), .d_dfp_rdata(d_dfp_rdata), .d_dfp_resp(d_dfp_resp),
      .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
      .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
      .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic feed_beats(input logic [31:0] tag, input logic [255:0] line);
      for (int k = 0; k < 4; k++) begin
         bmem_rvalid = 1'b1;
         bmem_raddr  = tag;
         bmem_rdata  = line[k*64 +: 64];
         tick();
      end
      bmem_rvalid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      vectors += 7;
      if (i_dfp_resp !== 1'b0) begin miscompares++; $display("FAIL rst_i_resp got %b exp 0", i_dfp_resp); end
      if (d_dfp_resp !== 1'b0) begin miscompares++; $display("FAIL rst_d_resp got %b exp 0", d_dfp_resp); end
      if (i_dfp_rdata !== 256'h0) begin miscompares++; $display("FAIL rst_i_rdata got %h exp 0", i_dfp_rdata); end
      if (d_dfp_rdata !== 256'h0) begin miscompares++; $display("FAIL rst_d_rdata got %h exp 0", d_dfp_rdata); end
      if ({bmem_read, bmem_write} !== 2'b00) begin miscompares++; $display("FAIL rst_cmd got %b exp 00", {bmem_read, bmem_write}); end
      if (bmem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr got %h exp 0", bmem_addr); end
      if (bmem_wdata !== 64'h0) begin miscompares++; $display("FAIL rst_wdata got %h exp 0", bmem_wdata); end
   endtask

   task automatic test_icache_read;
      logic [255:0] line;
      line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      i_dfp_addr = 32'h0000_104C;
      i_dfp_read = 1'b1;
      tick();
      vectors += 3;
      if (bmem_read !== 1'b1) begin miscompares++; $display("FAIL ir两_read_cmd got %b exp 1", bmem_read); end
      if (bmem_write !== 1'b0) begin miscompares++; $display("FAIL ird_no_write got %b exp 0", bmem_write); end
      if (bmem_addr !== 32'h0000_1040) begin miscompares++; $display("FAIL ird_addr got %h exp 00001040", bmem_addr); end
      tick();
      vectors++;
      if (bmem_read !== 1'b0) begin miscompares++; $display("FAIL ird_read_once got %b exp 0", bmem_read); end
      feed_beats(32'h0000_1040, line);
      vectors += 3;
      if (i_dfp_resp !== 1'b1) begin miscompares++; $display("FAIL ird_resp got %b exp 1", i_dfp_resp); end
      if (d_dfp_resp !== 1'b0) begin miscompares++; $display("FAIL ird_d_resp got %b exp 0", d_dfp_resp); end
      if (i_dfp_rdata !== line) begin miscompares++; $display("FAIL ird_rdata got %h exp %h", i_dfp_rdata, line); end
      i_dfp_read = 1'b0;
      tick();
      vectors += 2;
      if (i_dfp_resp !== 1'b0) begin miscompares++; $display("FAIL ird_resp_pulse got %b exp 0", i_dfp_resp); end
      if (i_dfp_rdata !== line) begin miscompares++; $display("FAIL ird_rdata_hold got %h exp %h", i_dfp_rdata, line); end
   endtask

   task automatic test_dcache_write_stall;
      logic [63:0] exp_wd [6];
      logic        rdy    [6];
      exp_wd = '{64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B, 64'hBBBB_0000_0000_000B,
                 64'hBBBB_0000_0000_000B, 64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D};
      rdy    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      d_dfp_addr  = 32'h8000_0020;
      d_dfp_wdata = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                     64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
      d_dfp_write = 1'b1;
      tick();
      vectors++;
      if (bmem_addr !== 32'h8000_0020) begin miscompares++; $display("FAIL wr_addr got %h exp 80000020", bmem_addr); end
      for (int i = 0; i < 6; i++) begin
         vectors += 3;
         if (bmem_write !== 1'b1) begin miscompares++; $display("FAIL wr_valid[%0d] got %b exp 1", i, bmem_write); end
         if (bmem_read !== 1'b0) begin miscompares++; $display("FAIL wr_no_read[%0d] got %b exp 0", i, bmem_read); end
         if (bmem_wdata !== exp_wd[i]) begin miscompares++; $display("FAIL wr_beat[%0d] got %h exp %h", i, bmem_wdata, exp_wd[i]); end
         bmem_ready = rdy[i];
         tick();
      end
      bmem_ready = 1'b1;
      vectors += 3;
      if (d_dfp_resp !== 1'b1) begin miscompares++; $display("FAIL wr_resp got %b exp 1", d_dfp_resp); end
      if (i_dfp_resp !== 1'b0) begin miscompares++; $display("FAIL wr_i_resp got %b exp 0", i_dfp_resp); end
      if (bmem_write !== 1'b0) begin miscompares++; $display("FAIL wr_done got %b exp 0", bmem_write); end
      d_dfp_write = 1'b0;
      tick();
   endtask

   task automatic test_simultaneous;
      logic [255:0] dline, iline;
      logic [31:0]  a1, a2;
      logic [255:0] l1, l2;
      dline = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
      iline = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
      a1 = FIRST_IS_D ? 32'h0000_3000 : 32'h0000_2000;
      a2 = FIRST_IS_D ? 32'h0000_2000 : 32'h0000_3000;
      l1 = FIRST_IS_D ? dline : iline;
      l2 = FIRST_IS_D ? iline : dline;
      i_dfp_addr = 32'h0000_2000;
      d_dfp_addr = 32'h0000_3000;
      i_dfp_read = 1'b1;
      d_dfp_read = 1'b1;
      tick();
      vectors++;
      if (bmem_addr !== a1) begin miscompares++; $display("FAIL arb_first_addr got %h exp %h", bmem_addr, a1); end
      tick();
      feed_beats(a1, l1);
      vectors += 2;
      if ({d_dfp_resp, i_dfp_resp} !== (FIRST_IS_D ? 2'b10 : 2'b01)) begin
         miscompares++; $display("FAIL arb_first_resp got %b exp %b", {d_dfp_resp, i_dfp_resp}, FIRST_IS_D ? 2'b10 : 2'b01);
      end
      if ((FIRST_IS_D ? d_dfp_rdata : i_dfp_rdata) !== l1) begin
         miscompares++; $display("FAIL arb_first_rdata got %h exp %h", FIRST_IS_D ? d_dfp_rdata : i_dfp_rdata, l1);
      end
      if (FIRST_IS_D) d_dfp_read = 1'b0; else i_dfp_read = 1'b0;
      tick();
      tick();
      vectors += 2;
      if (bmem_read !== 1'b1) begin miscompares++; $display("FAIL arb_second_read got %b exp 1", bmem_read); end
      if (bmem_addr !== a2) begin miscompares++; $display("FAIL arb_second_addr got %h exp %h", bmem_addr, a2); end
      tick();
      feed_beats(a2, l2);
      vectors += 3;
      if ({d_dfp_resp, i_dfp_resp} !== (FIRST_IS_D ? 2'b01 : 2'b10)) begin
         miscompares++; $display("FAIL arb_second_resp got %b exp %b", {d_dfp_resp, i_dfp_resp}, FIRST_IS_D ? 2'b01 : 2'b10);
      end
      if (i_dfp_rdata !== iline) begin miscompares++; $display("FAIL arb_i_rdata got %h exp %h", i_dfp_rdata, iline); end
      if (d_dfp_rdata !== dline) begin miscompares++; $display("FAIL arb_d_rdata got %h exp %h", d_dfp_rdata, dline); end
      i_dfp_read = 1'b0;
      d_dfp_read = 1'b0;
      tick();
   endtask

   task automatic test_tag_drop;
      logic [31:0]  tags [5];
      logic [63:0]  dat  [5];
      logic [255:0] line;
      tags = '{32'h100, 32'h200, 32'h100, 32'h100, 32'h100};
      dat  = '{64'hA0, 64'hDEAD_BEEF, 64'hA1, 64'hA2, 64'hA3};
      line = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
      i_dfp_addr = 32'h0000_0100;
      i_dfp_read = 1'b1;
      tick();
      tick();
      for (int k = 0; k < 5; k++) begin
         if (k == 4) begin
            vectors++;
            if (i_dfp_resp !== 1'b0) begin miscompares++; $display("FAIL tag_early_resp got %b exp 0", i_dfp_resp); end
         end
         bmem_rvalid = 1'b1;
         bmem_raddr  = tags[k];
         bmem_rdata  = dat[k];
         tick();
      end
      bmem_rvalid = 1'b0;
      vectors += 2;
      if (i_dfp_resp !== 1'b1) begin miscompares++; $display("FAIL tag_resp got %b exp 1", i_dfp_resp); end
      if (i_dfp_rdata !== line) begin miscompares++; $display("FAIL tag_rdata got %h exp %h", i_dfp_rdata, line); end
      i_dfp_read = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_burst;
      logic [255:0] wl;
      wl = {64'h0404, 64'h0303, 64'h0202, 64'h0101};
      d_dfp_addr  = 32'h0000_4000;
      d_dfp_wdata = wl;
      d_dfp_write = 1'b1;
      tick();
      tick();
      vectors++;
      if (bmem_wdata !== 64'h0202) begin miscompares++; $display("FAIL mrst_beat1 got %h exp 0202", bmem_wdata); end
      rst = 1'b1;
      d_dfp_write = 1'b0;
      tick();
      rst = 1'b0;
      vectors += 4;
      if (bmem_write !== 1'b0) begin miscompares++; $display("FAIL mrst_write got %b exp 0", bmem_write); end
      if (d_dfp_resp !== 1'b0) begin miscompares++; $display("FAIL mrst_resp got %b exp 0", d_dfp_resp); end
      if (bmem_addr !== 32'h0) begin miscompares++; $display("FAIL mrst_addr got %h exp 0", bmem_addr); end
      if (d_dfp_rdata !== 256'h0) begin miscompares++; $display("FAIL mrst_d_rdata got %h exp 0", d_dfp_rdata); end
      feed_beats(32'h0, {64'hF3, 64'hF2, 64'hF1, 64'hF0});
      vectors += 2;
      if ({i_dfp_resp, d_dfp_resp} !== 2'b00) begin miscompares++; $display("FAIL idle_beats_resp got %b exp 00", {i_dfp_resp, d_dfp_resp}); end
      if (i_dfp_rdata !== 256'h0) begin miscompares++; $display("FAIL idle_beats_rdata got %h exp 0", i_dfp_rdata); end
      d_dfp_write = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         vectors += 2;
         if (bmem_write !== 1'b1) begin miscompares++; $display("FAIL fresh_write[%0d] got %b exp 1", k, bmem_write); end
         if (bmem_wdata !== wl[k*64 +: 64]) begin miscompares++; $display("FAIL fresh_beat[%0d] got %h exp %h", k, bmem_wdata, wl[k*64 +: 64]); end
      end
      tick();
      vectors += 2;
      if (d_dfp_resp !== 1'b1) begin miscompares++; $display("FAIL fresh_resp got %b exp 1", d_dfp_resp); end
      if (bmem_write !== 1'b0) begin miscompares++; $display("FAIL fresh_done got %b exp 0", bmem_write); end
      d_dfp_write = 1'b0;
      tick();
      vectors++;
      if (d_dfp_resp !== 1'b0) begin miscompares++; $display("FAIL fresh_resp_pulse got %b exp 0", d_dfp_resp); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      i_dfp_addr  = '0;
      i_dfp_read  = 1'b0;
      d_dfp_addr  = '0;
      d_dfp_read  = 1'b0;
      d_dfp_write = 1'b0;
      d_dfp_wdata = '0;
      bmem_ready  = 1'b1;
      bmem_raddr  = '0;
      bmem_rdata  = '0;
      bmem_rvalid = 1'b0;
      #1;
      test_reset();
      test_icache_read();
      test_dcache_write_stall();
      test_simultaneous();
      test_tag_drop();
      test_reset_mid_burst();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
